// File: rtl/fport_check.sv
// fport_check: synchronises a constant-pattern bus, waits a settle window, then flags and counts mismatches
module fport_check #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1010,
  parameter int SETTLE = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic             clear,
  output logic             busy,
  output logic             ok,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] sampled
);
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {IDLE, SET, CHK} state_t;
  state_t state, nxt;
  logic [SW-1:0] cnt;
  logic [WIDTH-1:0] s1;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = clear ? IDLE :
          (state == IDLE && start) ? SET :
          (state == SET && cnt == '0) ? CHK : state;
  always_comb begin
    busy = state != IDLE;
    ok = state == CHK && !err;
  end
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= '0;
      sampled <= '0;
      cnt <= '0;
      err <= 1'b0;
      err_count <= '0;
    end else begin
      s1 <= data;
      sampled <= s1;
      if (clear) begin
        cnt <= '0;
        err <= 1'b0;
        err_count <= '0;
      end else if (state == IDLE && start) begin
        cnt <= SW'(SETTLE - 1);
        err <= 1'b0;
        err_count <= '0;
      end else if (state == SET) cnt <= cnt - SW'(1);
      else if (state == CHK && sampled != PATTERN) begin
        err <= 1'b1;
        if (~&err_count) err_count <= err_count + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_fport_check.sv
// tb_fport_check: directed and random stimulus against a cycle-count reference model
module tb_fport_check;
  localparam logic [3:0] PAT = 4'b1010;
  localparam int SETTLE = 10;
  logic clk = 0, rst = 1, start = 0, clear = 0;
  logic [3:0] data = PAT;
  logic busy, ok, err, busy2, ok2, err2;
  logic [7:0] err_count;
  logic [1:0] err_count2;
  logic [3:0] sampled, sampled2;
  int vecs = 0, miscmp = 0;
  int t = -1;
  logic m_err = 0;
  int m_cnt8 = 0, m_cnt2 = 0;
  logic [3:0] q[$];

  always #5 clk = ~clk;

  fport_check #(.WIDTH(4), .PATTERN(PAT), .SETTLE(SETTLE), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .data(data), .start(start), .clear(clear),
    .busy(busy), .ok(ok), .err(err), .err_count(err_count), .sampled(sampled));
  fport_check #(.WIDTH(4), .PATTERN(PAT), .SETTLE(SETTLE), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .data(data), .start(start), .clear(clear),
    .busy(busy2), .ok(ok2), .err(err2), .err_count(err_count2), .sampled(sampled2));

  task chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vecs++;
    assert (o === e) else begin
      miscmp++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, o, e, $time);
    end
  endtask

  // t = edges since the run was accepted (-1 idle); checking happens once t exceeds SETTLE
  task step(input logic [3:0] d, input logic s, input logic c, input logic r);
    data = d; start = s; clear = c; rst = r;
    @(posedge clk);
    if (r) begin
      t = -1; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
      q = '{4'd0, 4'd0};
    end else begin
      if (c) begin
        t = -1; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
      end else if (t < 0) begin
        if (s) begin t = 1; m_err = 0; m_cnt8 = 0; m_cnt2 = 0; end
      end else begin
        if (t > SETTLE && q[0] != PAT) begin
          m_err = 1;
          m_cnt8 = m_cnt8 == 255 ? 255 : m_cnt8 + 1;
          m_cnt2 = m_cnt2 == 3 ? 3 : m_cnt2 + 1;
        end
        if (t <= SETTLE) t++;
      end
      q.push_back(d);
      void'(q.pop_front());
    end
    #1;
    chk("busy", busy, t >= 1);
    chk("ok", ok, t > SETTLE && !m_err);
    chk("err", err, m_err);
    chk("err_count", err_count, m_cnt8);
    chk("sampled", sampled, q[0]);
    chk("busy2", busy2, t >= 1);
    chk("ok2", ok2, t > SETTLE && !m_err);
    chk("err2", err2, m_err);
    chk("err_count2", err_count2, m_cnt2);
    chk("sampled2", sampled2, q[0]);
  endtask

  initial begin
    q = '{4'd0, 4'd0};
    step(PAT, 0, 0, 1);
    step(PAT, 0, 0, 1);
    chk("reset_busy", busy, 0);
    step(PAT, 1, 0, 0);
    chk("start_busy", busy, 1);
    repeat (SETTLE + 2) step(PAT, 0, 0, 0);
    chk("settled_ok", ok, 1);
    repeat (50) step(PAT, 0, 0, 0);
    repeat (3) step(4'b1011, 0, 0, 0);
    repeat (10) step(PAT, 0, 0, 0);
    chk("three_errs", err_count, 3);
    chk("ok_stays_low", ok, 0);
    repeat (10) step(4'b0000, 0, 0, 0);
    repeat (4) step(PAT, 0, 0, 0);
    chk("sat_cnt2", err_count2, 3);
    chk("cnt8_13", err_count, 13);
    step(PAT, 0, 1, 0);
    step(PAT, 1, 1, 0);
    chk("clear_wins", busy, 0);
    repeat (3) step(PAT, 0, 0, 0);
    step(PAT, 1, 0, 0);
    repeat (5) step(PAT, 0, 0, 0);
    repeat (3) step(4'b0000, 0, 0, 0);
    repeat (2) step(PAT, 0, 0, 0);
    repeat (20) step(PAT, 0, 0, 0);
    chk("settle_ignored", err, 0);
    repeat (2) step(4'b0001, 0, 0, 0);
    repeat (3) step(PAT, 0, 0, 0);
    step(PAT, 0, 1, 0);
    chk("clear_mid_check", err_count, 0);
    step(PAT, 1, 0, 0);
    repeat (4) step(PAT, 1, 0, 0);
    repeat (3) step(PAT, 0, 0, 0);
    step(PAT, 0, 0, 1);
    chk("rst_mid_settle", busy, 0);
    step(PAT, 1, 0, 0);
    step(PAT, 0, 0, 0);
    step(PAT, 1, 0, 0);
    repeat (SETTLE + 3) step(4'b1111, 0, 0, 0);
    step(PAT, 0, 0, 1);
    chk("rst_mid_check", err, 0);
    for (int i = 0; i < 3000; i++)
      step(($urandom % 4 == 0) ? 4'($urandom) : PAT,
           $urandom % 20 == 0, $urandom % 60 == 0, $urandom % 200 == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
